// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bundles the IF read port, the EX load/store port and the
//                single-port SRAM bus seen by mem_arbiter.
//                Optional debug master ports exist when MEM_ARB_DBG_EN is
//                defined.
//  Modports    : slave  - arbiter view (requests in, grants/data/SRAM out)
//                master - requester view (requests out, grants/data in)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // IF master
  logic                  if_req_i;
  logic [ADDR_W-1:0]     if_addr_i;
  logic                  if_gnt_o;
  logic                  if_rvalid_o;
  logic [DATA_W-1:0]     if_rdata_o;
  // EX master
  logic                  ex_req_i;
  logic                  ex_we_i;
  logic [ADDR_W-1:0]     ex_addr_i;
  logic [DATA_W-1:0]     ex_wdata_i;
  logic [DATA_W/8-1:0]   ex_be_i;
  logic                  ex_gnt_o;
  logic                  ex_rvalid_o;
  logic [DATA_W-1:0]     ex_rdata_o;
  // pipeline hold
  logic                  hold_o;
  // SRAM side
  logic                  mem_en_o;
  logic                  mem_we_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [DATA_W-1:0]     mem_wdata_o;
  logic [DATA_W/8-1:0]   mem_be_o;
  logic [DATA_W-1:0]     mem_rdata_i;
`ifdef MEM_ARB_DBG_EN
  // debug master
  logic                  dbg_req_i;
  logic                  dbg_we_i;
  logic [ADDR_W-1:0]     dbg_addr_i;
  logic [DATA_W-1:0]     dbg_wdata_i;
  logic                  dbg_gnt_o;
  logic                  dbg_rvalid_o;
  logic [DATA_W-1:0]     dbg_rdata_o;
`endif

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ex_req_i, ex_we_i, ex_addr_i, ex_wdata_i, ex_be_i,
    output ex_gnt_o, ex_rvalid_o, ex_rdata_o,
    output hold_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_rdata_i
`ifdef MEM_ARB_DBG_EN
    , input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i
    , output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o
`endif
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output ex_req_i, ex_we_i, ex_addr_i, ex_wdata_i, ex_be_i,
    input  ex_gnt_o, ex_rvalid_o, ex_rdata_o,
    input  hold_o
`ifdef MEM_ARB_DBG_EN
    , output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i
    , input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o
`endif
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one single-port synchronous SRAM between the IF and
//                EX ports. One access per cycle, EX > IF priority with an IF
//                anti-starvation boost, 1-cycle read data routed back to the
//                owning master, hold request for the pipeline controller.
//  Ports       : clk  - core clock
//                rst  - asynchronous active-high reset
//                bus  - mem_arbiter_if.slave (IF, EX, hold, SRAM signals)
//  Options     : MEM_ARB_DBG_EN - adds a debug master with absolute priority
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  wire logic       clk,
  input  wire logic       rst,
  mem_arbiter_if.slave    bus
);
  localparam int         BE_W       = DATA_W / 8;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

`ifdef MEM_ARB_DBG_EN
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_EX = 2'd2, OWN_DBG = 2'd3} owner_t;
`else
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_EX = 2'd2} owner_t;
`endif

  owner_t      owner_q, owner_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;

  logic              boost;
  logic              dbg_gnt;
  logic              if_gnt;
  logic              ex_gnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q      <= OWN_NONE;
      starve_cnt_q <= '0;
    end else begin
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    dbg_gnt      = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_be       = '0;
    owner_d      = OWN_NONE;
    starve_cnt_d = starve_cnt_q;

    boost = bus.if_req_i && (starve_cnt_q == STARVE_LIM);
`ifdef MEM_ARB_DBG_EN
    dbg_gnt = bus.dbg_req_i;
`endif
    // A boosted IF beats EX but never the debug master.
    if_gnt = !dbg_gnt && bus.if_req_i && (boost || !bus.ex_req_i);
    ex_gnt = !dbg_gnt && bus.ex_req_i && !if_gnt;

    // Any denied IF cycle (including a debug win) counts toward the boost;
    // saturation keeps the boost armed while debug keeps winning.
    if (bus.if_req_i && !if_gnt) begin
      if (starve_cnt_q != STARVE_LIM) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end else begin
      starve_cnt_d = '0;
    end

`ifdef MEM_ARB_DBG_EN
    if (dbg_gnt) begin
      mem_en   = 1'b1;
      mem_we   = bus.dbg_we_i;
      mem_addr = bus.dbg_addr_i;
      mem_be   = '1;
      if (bus.dbg_we_i) begin
        mem_wdata = bus.dbg_wdata_i;
      end else begin
        owner_d = OWN_DBG;
      end
    end else
`endif
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = bus.if_addr_i;
      mem_be   = '1;
      owner_d  = OWN_IF;
    end else if (ex_gnt) begin
      mem_en   = 1'b1;
      mem_we   = bus.ex_we_i;
      mem_addr = bus.ex_addr_i;
      mem_be   = bus.ex_be_i;
      if (bus.ex_we_i) begin
        mem_wdata = bus.ex_wdata_i;
      end else begin
        owner_d = OWN_EX;
      end
    end
  end

  assign bus.if_gnt_o    = if_gnt;
  assign bus.ex_gnt_o    = ex_gnt;
  assign bus.hold_o      = bus.ex_req_i && !ex_gnt;
  assign bus.mem_en_o    = mem_en;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_wdata_o = mem_wdata;
  assign bus.mem_be_o    = mem_be;

  // Read data is steered purely from the registered owner so a reset
  // mid-access drops the pending response immediately.
  assign bus.if_rvalid_o = (owner_q == OWN_IF);
  assign bus.if_rdata_o  = (owner_q == OWN_IF) ? bus.mem_rdata_i : '0;
  assign bus.ex_rvalid_o = (owner_q == OWN_EX);
  assign bus.ex_rdata_o  = (owner_q == OWN_EX) ? bus.mem_rdata_i : '0;
`ifdef MEM_ARB_DBG_EN
  assign bus.dbg_gnt_o    = dbg_gnt;
  assign bus.dbg_rvalid_o = (owner_q == OWN_DBG);
  assign bus.dbg_rdata_o  = (owner_q == OWN_DBG) ? bus.mem_rdata_i : '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. A behavioural SRAM
//                answers accesses; read expectations are queued at grant time
//                and compared when read data returns.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] sram    [256];
  logic [31:0] ref_mem [256];

  typedef struct {int due; int who; logic [31:0] data;} exp_t;
  exp_t sbq[$];

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  // behavioural single-port SRAM with 1-cycle read latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      bus.mem_rdata_i <= '0;
    end else if (bus.mem_en_o) begin
      if (bus.mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be_o[b]) sram[bus.mem_addr_o[9:2]][b*8 +: 8] = bus.mem_wdata_o[b*8 +: 8];
      end else begin
        bus.mem_rdata_i <= sram[bus.mem_addr_o[9:2]];
      end
    end
  end

  // read-data monitor: every cycle out of reset, rvalid/rdata must match the queue
  logic m_if, m_ex, m_dbg;
  logic [31:0] d_if, d_ex, d_dbg;
  exp_t e;
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
    end else begin
      m_if = 1'b0; m_ex = 1'b0; m_dbg = 1'b0;
      d_if = '0;   d_ex = '0;   d_dbg = '0;
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        case (e.who)
          1: begin m_if = 1'b1; d_if = e.data; end
          2: begin m_ex = 1'b1; d_ex = e.data; end
          default: begin m_dbg = 1'b1; d_dbg = e.data; end
        endcase
      end
      total++;
      if (bus.if_rvalid_o !== m_if || bus.if_rdata_o !== d_if) begin
        bad++;
        $display("FAIL if_resp cyc=%0d got v=%b d=%h want v=%b d=%h", cyc, bus.if_rvalid_o, bus.if_rdata_o, m_if, d_if);
      end
      total++;
      if (bus.ex_rvalid_o !== m_ex || bus.ex_rdata_o !== d_ex) begin
        bad++;
        $display("FAIL ex_resp cyc=%0d got v=%b d=%h want v=%b d=%h", cyc, bus.ex_rvalid_o, bus.ex_rdata_o, m_ex, d_ex);
      end
`ifdef MEM_ARB_DBG_EN
      total++;
      if (bus.dbg_rvalid_o !== m_dbg || bus.dbg_rdata_o !== d_dbg) begin
        bad++;
        $display("FAIL dbg_resp cyc=%0d got v=%b d=%h want v=%b d=%h", cyc, bus.dbg_rvalid_o, bus.dbg_rdata_o, m_dbg, d_dbg);
      end
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_req_i   = 1'b0; bus.if_addr_i  = '0;
    bus.ex_req_i   = 1'b0; bus.ex_we_i    = 1'b0; bus.ex_addr_i = '0;
    bus.ex_wdata_i = '0;   bus.ex_be_i    = 4'hF;
`ifdef MEM_ARB_DBG_EN
    bus.dbg_req_i = 1'b0; bus.dbg_we_i = 1'b0; bus.dbg_addr_i = '0; bus.dbg_wdata_i = '0;
`endif
  endtask

  task automatic push_read(input int who, input logic [31:0] addr);
    sbq.push_back('{cyc + 1, who, ref_mem[addr[9:2]]});
  endtask

  task automatic test_reset();
    idle();
    step(); step();
    @(negedge clk);
    total++;
    if ({bus.if_gnt_o, bus.ex_gnt_o, bus.hold_o, bus.mem_en_o, bus.mem_we_o, bus.if_rvalid_o, bus.ex_rvalid_o} !== 7'b0
        || bus.if_rdata_o !== 32'h0 || bus.ex_rdata_o !== 32'h0 || bus.mem_addr_o !== 32'h0 || bus.mem_be_o !== 4'h0) begin
      bad++;
      $display("FAIL reset_outputs got gnt=%b%b hold=%b en=%b rv=%b%b want all zero",
               bus.if_gnt_o, bus.ex_gnt_o, bus.hold_o, bus.mem_en_o, bus.if_rvalid_o, bus.ex_rvalid_o);
    end
    total++;
    if (dut.starve_cnt_q !== 4'd0) begin
      bad++; $display("FAIL reset_starve got %0d want 0", dut.starve_cnt_q);
    end
    step(); rst = 1'b0;
    step();
  endtask

  task automatic test_if_read();
    step(); idle();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    @(negedge clk);
    total++;
    if ({bus.if_gnt_o, bus.ex_gnt_o, bus.mem_en_o, bus.mem_we_o} !== 4'b1010
        || bus.mem_addr_o !== 32'h100 || bus.mem_be_o !== 4'hF || bus.hold_o !== 1'b0) begin
      bad++;
      $display("FAIL if_read_grant got gnt=%b%b en=%b we=%b a=%h be=%h want 1 0 1 0 100 f",
               bus.if_gnt_o, bus.ex_gnt_o, bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_be_o);
    end
    push_read(1, 32'h100);
    step(); idle();
  endtask

  task automatic test_ex_write();
    step(); idle();
    bus.ex_req_i = 1'b1; bus.ex_we_i = 1'b1; bus.ex_addr_i = 32'h200;
    bus.ex_wdata_i = 32'h12345678; bus.ex_be_i = 4'b0011;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h200;
    @(negedge clk);
    total++;
    if ({bus.ex_gnt_o, bus.if_gnt_o, bus.mem_we_o, bus.hold_o} !== 4'b1010 || bus.mem_be_o !== 4'b0011
        || bus.mem_wdata_o !== 32'h12345678 || bus.mem_addr_o !== 32'h200) begin
      bad++;
      $display("FAIL ex_write got exg=%b ifg=%b we=%b be=%b wd=%h a=%h want 1 0 1 0011 12345678 200",
               bus.ex_gnt_o, bus.if_gnt_o, bus.mem_we_o, bus.mem_be_o, bus.mem_wdata_o, bus.mem_addr_o);
    end
    ref_mem[128] = merge(ref_mem[128], 32'h12345678, 4'b0011);
    step();
    bus.ex_req_i = 1'b0; bus.ex_we_i = 1'b0;
    @(negedge clk);
    total++;
    if (bus.if_gnt_o !== 1'b1 || bus.ex_gnt_o !== 1'b0) begin
      bad++; $display("FAIL if_retry got ifg=%b exg=%b want 1 0", bus.if_gnt_o, bus.ex_gnt_o);
    end
    push_read(1, 32'h200);
    step(); idle();
  endtask

  task automatic test_boost();
    logic exp_if;
    step(); idle();
    bus.ex_req_i = 1'b1; bus.ex_addr_i = 32'h10;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h20;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      @(negedge clk);
      exp_if = (k == 4);
      total++;
      if (bus.if_gnt_o !== exp_if || bus.ex_gnt_o !== !exp_if || bus.hold_o !== exp_if) begin
        bad++;
        $display("FAIL boost k=%0d got ifg=%b exg=%b hold=%b want %b %b %b",
                 k, bus.if_gnt_o, bus.ex_gnt_o, bus.hold_o, exp_if, !exp_if, exp_if);
      end
      total++;
      if (dut.starve_cnt_q !== 4'((k <= 4) ? k : 0)) begin
        bad++; $display("FAIL starve_cnt k=%0d got %0d want %0d", k, dut.starve_cnt_q, (k <= 4) ? k : 0);
      end
      if (exp_if) push_read(1, 32'h20);
      else        push_read(2, 32'h10);
    end
    step(); idle();
  endtask

  task automatic test_back_to_back();
    step(); idle();
    bus.ex_req_i = 1'b1; bus.ex_addr_i = 32'h10;
    @(negedge clk);
    total++;
    if (bus.ex_gnt_o !== 1'b1 || bus.mem_addr_o !== 32'h10) begin
      bad++; $display("FAIL b2b_ex got exg=%b a=%h want 1 10", bus.ex_gnt_o, bus.mem_addr_o);
    end
    push_read(2, 32'h10);
    step(); idle();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h20;
    @(negedge clk);
    total++;
    if (bus.if_gnt_o !== 1'b1 || bus.mem_addr_o !== 32'h20) begin
      bad++; $display("FAIL b2b_if got ifg=%b a=%h want 1 20", bus.if_gnt_o, bus.mem_addr_o);
    end
    push_read(1, 32'h20);
    step(); idle();
    step();
  endtask

  task automatic test_reset_mid_read();
    // IF read cut off by reset
    step(); idle();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    @(negedge clk);
    push_read(1, 32'h100);
    step(); idle(); rst = 1'b1;
    #1;
    total++;
    if (bus.if_rvalid_o !== 1'b0 || bus.if_rdata_o !== 32'h0) begin
      bad++; $display("FAIL rst_if_drop got v=%b d=%h want 0 0", bus.if_rvalid_o, bus.if_rdata_o);
    end
    sbq.delete();
    step(); rst = 1'b0;
    // EX read with IF denied (starve_cnt becomes 1) cut off by reset
    step();
    bus.ex_req_i = 1'b1; bus.ex_addr_i = 32'h10;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h20;
    @(negedge clk);
    push_read(2, 32'h10);
    step(); idle(); rst = 1'b1;
    #1;
    total++;
    if (bus.ex_rvalid_o !== 1'b0 || dut.starve_cnt_q !== 4'd0) begin
      bad++; $display("FAIL rst_ex_drop got v=%b starve=%0d want 0 0", bus.ex_rvalid_o, dut.starve_cnt_q);
    end
    sbq.delete();
    step(); rst = 1'b0;
    // first grant after reset follows default priority
    step();
    bus.ex_req_i = 1'b1; bus.ex_addr_i = 32'h10;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h20;
    @(negedge clk);
    total++;
    if (bus.ex_gnt_o !== 1'b1 || bus.if_gnt_o !== 1'b0) begin
      bad++; $display("FAIL post_rst_prio got exg=%b ifg=%b want 1 0", bus.ex_gnt_o, bus.if_gnt_o);
    end
    push_read(2, 32'h10);
    step(); idle();
    step();
  endtask

  task automatic test_random();
    int m_starve;
    logic r_if, r_ex, r_we, boost, g_if, g_ex;
    logic [31:0] a_if, a_ex, wd;
    logic [3:0] be;
    m_starve = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      r_if = 1'($urandom_range(0, 1)); r_ex = 1'($urandom_range(0, 1)); r_we = 1'($urandom_range(0, 1));
      a_if = {22'd0, 6'($urandom_range(0, 15)), 2'b00};
      a_ex = {22'd0, 6'($urandom_range(0, 15)), 2'b00};
      wd = $urandom; be = 4'($urandom);
      bus.if_req_i = r_if; bus.if_addr_i = a_if;
      bus.ex_req_i = r_ex; bus.ex_we_i = r_we; bus.ex_addr_i = a_ex; bus.ex_wdata_i = wd; bus.ex_be_i = be;
      @(negedge clk);
      boost = r_if && (m_starve == SM);
      g_if = r_if && (boost || !r_ex);
      g_ex = r_ex && !g_if;
      total++;
      if (bus.if_gnt_o !== g_if || bus.ex_gnt_o !== g_ex || bus.hold_o !== (r_ex && !g_ex)
          || bus.mem_en_o !== (g_if || g_ex) || bus.mem_we_o !== (g_ex && r_we)
          || bus.mem_addr_o !== (g_if ? a_if : (g_ex ? a_ex : 32'h0))) begin
        bad++;
        $display("FAIL random i=%0d got ifg=%b exg=%b hold=%b en=%b we=%b a=%h want %b %b %b %b %b",
                 i, bus.if_gnt_o, bus.ex_gnt_o, bus.hold_o, bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o,
                 g_if, g_ex, r_ex && !g_ex, g_if || g_ex, g_ex && r_we);
      end
      if (g_if) push_read(1, a_if);
      else if (g_ex && !r_we) push_read(2, a_ex);
      else if (g_ex) ref_mem[a_ex[9:2]] = merge(ref_mem[a_ex[9:2]], wd, be);
      if (r_if && !g_if) m_starve = (m_starve == SM) ? SM : m_starve + 1;
      else m_starve = 0;
    end
    step(); idle();
    step();
  endtask

`ifdef MEM_ARB_DBG_EN
  task automatic test_dbg();
    step(); idle();
    bus.dbg_req_i = 1'b1; bus.dbg_addr_i = 32'h100;
    bus.ex_req_i = 1'b1; bus.ex_addr_i = 32'h10;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h20;
    @(negedge clk);
    total++;
    if ({bus.dbg_gnt_o, bus.ex_gnt_o, bus.if_gnt_o, bus.hold_o} !== 4'b1001
        || bus.mem_addr_o !== 32'h100 || bus.mem_be_o !== 4'hF) begin
      bad++;
      $display("FAIL dbg_prio got dbg=%b ex=%b if=%b hold=%b a=%h want 1 0 0 1 100",
               bus.dbg_gnt_o, bus.ex_gnt_o, bus.if_gnt_o, bus.hold_o, bus.mem_addr_o);
    end
    push_read(3, 32'h100);
    step(); idle();
    step();
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hC0DE_0000 + i;
    ref_mem[64]  = 32'hDEADBEEF;
    ref_mem[128] = 32'hAAAAAAAA;
    ref_mem[4]   = 32'h1111_0010;
    ref_mem[8]   = 32'h2222_0020;
    for (int i = 0; i < 256; i++) sram[i] = ref_mem[i];
    idle();
    test_reset();
    test_if_read();
    test_ex_write();
    test_boost();
    test_back_to_back();
    test_reset_mid_read();
`ifdef MEM_ARB_DBG_EN
    test_dbg();
`endif
    test_random();
    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous SRAM between the instruction-fetch port (IF) and the execute-stage load/store port (EX).
- Issues at most one memory access per cycle using fixed priority plus an IF anti-starvation boost.
- Routes the 1-cycle-latency read data back to whichever master owned the access.
- Drives the pipeline hold request consumed by ctrl's bus-hold input.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- STARVE_MAX, 4, consecutive denied IF-request cycles before IF is boosted over EX (range 1..15).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- if_req_i  in  1  IF read request
- if_addr_i  in  ADDR_W  IF address
- if_gnt_o  out  1  IF granted this cycle
- if_rvalid_o  out  1  IF read data valid
- if_rdata_o  out  DATA_W  IF read data
- ex_req_i  in  1  EX request
- ex_we_i  in  1  EX write (1) / read (0)
- ex_addr_i  in  ADDR_W  EX address
- ex_wdata_i  in  DATA_W  EX write data
- ex_be_i  in  DATA_W/8  EX byte enables
- ex_gnt_o  out  1  EX granted this cycle
- ex_rvalid_o  out  1  EX read data valid
- ex_rdata_o  out  DATA_W  EX read data
- hold_o  out  1  EX request pending but not granted
- mem_en_o  out  1  SRAM access enable
- mem_we_o  out  1  SRAM write enable
- mem_addr_o  out  ADDR_W  SRAM address
- mem_wdata_o  out  DATA_W  SRAM write data
- mem_be_o  out  DATA_W/8  SRAM byte enables
- mem_rdata_i  in  DATA_W  SRAM read data, valid one cycle after the read access

Behaviour:
- Clock is clk; reset is rst, asynchronous, active-high.
- Reset values: starve_cnt=0, owner=NONE, both rvalid=0, both rdata=0. Grants, mem_* and hold_o are combinational and reset to 0 when no request is present.
- Grant is combinational, same cycle as the request.
  - Default priority is EX > IF.
  - When starve_cnt==STARVE_MAX and if_req_i=1, IF wins over EX.
- Only the granted master drives mem_*. mem_en_o = any grant.
  - IF access: mem_we_o=0, mem_be_o=all ones.
  - EX write: mem_we_o=1, mem_be_o=ex_be_i, mem_wdata_o=ex_wdata_i.
  - No grant: mem_addr_o/mem_wdata_o/mem_be_o driven 0.
- starve_cnt, 4-bit saturating:
  - Increments when if_req_i=1 and if_gnt_o=0.
  - Clears on an IF grant or when if_req_i=0.
  - Holds at STARVE_MAX.
- Data-phase FSM, register owner ∈ {NONE, IF, EX}:
  - Each cycle, owner ← IF if IF granted; EX if EX read granted; otherwise NONE. An EX write sets NONE.
  - x_rvalid_o = (owner==x). x_rdata_o = mem_rdata_i when owner==x, else 0.
- Back-to-back grants are allowed every cycle. Read latency is exactly 1 cycle. Writes produce no rvalid.
- hold_o = ex_req_i & ~ex_gnt_o. It is 1 only in boosted cycles.
- Requesters hold req/addr/data stable until granted. The arbiter does not latch ungranted requests.
- Simultaneous EX write and IF read: only one is granted. The loser sees gnt=0 and retries the next cycle.
- Reset asserted mid-access: owner→NONE immediately and the pending rvalid is dropped. After reset the first grant follows default priority.
- Address alignment and range are not checked.

Optional Feature:
- Macro: MEM_ARB_DBG_EN.
- Defined: adds debug master ports dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o.
  - DBG has absolute priority over EX and over boosted IF; DBG writes use full byte enables.
  - owner gains state DBG.
  - A DBG grant counts as a denial for an IF request (starve_cnt increments) but does not clear the boost.
- Undefined: ports absent, owner is 2 states + NONE, behaviour as above.

Test Plan:
- IF-only read: if_req_i=1, addr 0x100, SRAM word 0xDEADBEEF -> if_gnt_o=1 in cycle 0; cycle 1 if_rvalid_o=1, if_rdata_o=0xDEADBEEF; ex_rvalid_o=0.
- EX write with IF contention: ex_req_i=1, we=1, addr 0x200, wdata 0x12345678, be 4'b0011 together with if_req_i=1 -> ex_gnt_o=1, if_gnt_o=0, mem_be_o=0011, no rvalid next cycle; IF granted the following cycle after EX drops its request.
- Starvation boost (STARVE_MAX=4): ex_req_i and if_req_i held high -> EX granted cycles 0-3; cycle 4 if_gnt_o=1, hold_o=1; cycle 5 EX granted again and starve_cnt=0.
- Back-to-back reads: EX read 0x10 in cycle 0, IF read 0x20 in cycle 1 -> ex_rvalid_o in cycle 1 only, if_rvalid_o in cycle 2 only, data matches each address.
- Reset mid-read: IF read granted in cycle 0, rst pulsed in cycle 1 -> if_rvalid_o=0 immediately, starve_cnt=0, no spurious rvalid after reset release.
- MEM_ARB_DBG_EN: dbg, ex and if requests all high -> dbg_gnt_o=1, ex/if gnt 0, hold_o=1; dbg read returns on dbg_rvalid_o one cycle later.
